// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   seq_state_e    : sequencer state with fixed 2-bit debug encodings
//   STATE_W        : width of the seq_state debug output
//   seq_cnt_width(): width of the shared qualification/hold counter
package pll_seq_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Counter must hold max(a,b); the +1 keeps a power-of-two terminal count representable.
  function automatic int unsigned seq_cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Signal bundle between the PLL wrapper side and the reset sequencer.
// Optional feature macro: PLL_RESET_SEQ_LOSS_COUNT_EN adds clear_count / loss_count.
//   pll_lock    : asynchronous PLL lock indication (into sequencer)
//   rst_out     : registered active-high downstream reset (out of sequencer)
//   seq_state   : current sequencer state, debug
//   lock_lost   : one-cycle pulse on lock loss while running
//   clear_count : clears the loss counter (macro only)
//   loss_count  : saturating lock-loss counter (macro only)
// Modports: master = PLL wrapper / consumer side, slave = sequencer.
interface pll_reset_seq_if
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  #(parameter int unsigned CNT_W = 8)
`endif
  ;
  import pll_seq_pkg::*;

  logic               pll_lock;
  logic               rst_out;
  logic [STATE_W-1:0] seq_state;
  logic               lock_lost;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic               clear_count;
  logic [CNT_W-1:0]   loss_count;

  modport master (output pll_lock, clear_count,
                  input  rst_out, seq_state, lock_lost, loss_count);
  modport slave  (input  pll_lock, clear_count,
                  output rst_out, seq_state, lock_lost, loss_count);
`else
  modport master (output pll_lock,
                  input  rst_out, seq_state, lock_lost);
  modport slave  (input  pll_lock,
                  output rst_out, seq_state, lock_lost);
`endif

endinterface

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clock : destination clock
//   reset : synchronous active-high reset, clears every stage to 0
//   i_d   : asynchronous input
//   o_q   : synchronized output, STAGES edges of latency
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift chain: bit 0 is the metastability-exposed capture flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Reset sequencer on the PLL output clock: qualifies the synchronized lock
// for LOCK_STABLE_CYCLES, holds rst_out for RESET_HOLD_CYCLES more, then
// releases it. Lock loss while running re-asserts reset and pulses lock_lost.
// Optional feature macro: PLL_RESET_SEQ_LOSS_COUNT_EN (saturating loss counter).
//   clock : PLL output clock, the only clock
//   reset : synchronous active-high reset
//   bus   : slave side of pll_reset_seq_if (pll_lock in; rst_out, seq_state,
//           lock_lost out; clear_count in / loss_count out with the macro)
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned CNT_W              = 8
) (
  input  logic           clock,
  input  logic           reset,
  pll_reset_seq_if.slave bus
);

  localparam int unsigned SEQ_CNT_W = seq_cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
  localparam logic [SEQ_CNT_W-1:0] STABLE_LAST = SEQ_CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [SEQ_CNT_W-1:0] HOLD_LAST   = SEQ_CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [SEQ_CNT_W-1:0] CNT_ONE     = SEQ_CNT_W'(1);

  // Elaboration-time parameter sanity.
  if (SYNC_STAGES < 2 || LOCK_STABLE_CYCLES < 1 || RESET_HOLD_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
    $error("pll_reset_seq: illegal parameter value");
  end

  logic                 w_lock_s;
  logic                 w_loss_evt;
  seq_state_e           r_state;
  logic [SEQ_CNT_W-1:0] r_cnt;
  logic                 r_rst_out;
  logic                 r_lock_lost;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (bus.pll_lock),
    .o_q   (w_lock_s)
  );

  // Lock dropping while running is the only event that counts as a loss.
  assign w_loss_evt = (r_state == RUN) && !w_lock_s;

  // Sequencer FSM; rst_out and lock_lost are updated on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_rst_out   <= 1'b1;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_lost <= 1'b0;
      case (r_state)
        WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end
        end
        STABLE: begin
          // Any dropout restarts qualification, even on the terminal count.
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == HOLD_LAST) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_rst_out <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (w_loss_evt) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_rst_out   <= 1'b1;
            r_lock_lost <= 1'b1;
          end
        end
        default: begin
          r_state   <= WAIT_LOCK;
          r_cnt     <= '0;
          r_rst_out <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rst_out   = r_rst_out;
  assign bus.seq_state = r_state;
  assign bus.lock_lost = r_lock_lost;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  localparam logic [CNT_W-1:0] LOSS_MAX = '1;
  localparam logic [CNT_W-1:0] LOSS_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_loss_count;

  // Counts on the edge that raises lock_lost; clear wins but keeps a coincident loss.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_loss_count <= '0;
    end else if (bus.clear_count) begin
      r_loss_count <= w_loss_evt ? LOSS_ONE : '0;
    end else if (w_loss_evt && (r_loss_count != LOSS_MAX)) begin
      r_loss_count <= r_loss_count + LOSS_ONE;
    end
  end

  assign bus.loss_count = r_loss_count;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq (SYNC_STAGES=2, LOCK_STABLE_CYCLES=4,
// RESET_HOLD_CYCLES=3, CNT_W=2). Expected per-edge state/rst_out/lock_lost
// tuples and loss counts are queued as stimulus is planned, then popped as
// the DUT is sampled 1 time unit after each rising edge.
module tb_pll_reset_seq;

  typedef struct packed {
    logic [1:0] st;
    logic       rst;
    logic       lost;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  exp_t       q_exp[$];
  logic [1:0] q_cnt[$];

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  pll_reset_seq_if #(.CNT_W(2)) bus ();
`else
  pll_reset_seq_if bus ();
`endif

  pll_reset_seq #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (4),
    .RESET_HOLD_CYCLES  (3),
    .CNT_W              (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int n, input logic [1:0] st, input logic rst, input logic lost);
    exp_t e;
    e.st = st; e.rst = rst; e.lost = lost;
    for (int i = 0; i < n; i++) q_exp.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e, obs;
    reset = 1'b1;
    bus.pll_lock = 1'b0;
    push_exp(3, 2'd0, 1'b1, 1'b0);
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    q_cnt.push_back(2'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      e = q_exp.pop_front();
      obs = {bus.seq_state, bus.rst_out, bus.lock_lost};
      n_total++;
      if (obs !== e)
        $display("FAIL reset k=%0d got st=%0d rst=%b lost=%b exp st=%0d rst=%b lost=%b",
                 k, obs.st, obs.rst, obs.lost, e.st, e.rst, e.lost);
      else n_pass++;
    end
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    begin
      logic [1:0] c;
      c = q_cnt.pop_front();
      n_total++;
      if (bus.loss_count !== c)
        $display("FAIL reset_loss_count got %0d exp %0d", bus.loss_count, c);
      else n_pass++;
    end
`endif
  endtask

  task automatic test_clean_lock();
    exp_t e, obs;
    reset = 1'b0;
    bus.pll_lock = 1'b1;
    push_exp(2, 2'd0, 1'b1, 1'b0);
    push_exp(4, 2'd1, 1'b1, 1'b0);
    push_exp(3, 2'd2, 1'b1, 1'b0);
    push_exp(3, 2'd3, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick();
      e = q_exp.pop_front();
      obs = {bus.seq_state, bus.rst_out, bus.lock_lost};
      n_total++;
      if (obs !== e)
        $display("FAIL clean_lock edge=%0d got st=%0d rst=%b lost=%b exp st=%0d rst=%b lost=%b",
                 k, obs.st, obs.rst, obs.lost, e.st, e.rst, e.lost);
      else n_pass++;
    end
  endtask

  task automatic test_glitch_stable();
    exp_t e, obs;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.pll_lock = 1'b1;
    // Lock dropout sampled at edge 4 is seen as lock_s low at edge 6.
    push_exp(2, 2'd0, 1'b1, 1'b0);
    push_exp(4, 2'd1, 1'b1, 1'b0);
    push_exp(1, 2'd0, 1'b1, 1'b0);
    push_exp(4, 2'd1, 1'b1, 1'b0);
    push_exp(3, 2'd2, 1'b1, 1'b0);
    push_exp(3, 2'd3, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) begin
      if (k == 4) bus.pll_lock = 1'b0;
      if (k == 5) bus.pll_lock = 1'b1;
      tick();
      e = q_exp.pop_front();
      obs = {bus.seq_state, bus.rst_out, bus.lock_lost};
      n_total++;
      if (obs !== e)
        $display("FAIL glitch_stable edge=%0d got st=%0d rst=%b lost=%b exp st=%0d rst=%b lost=%b",
                 k, obs.st, obs.rst, obs.lost, e.st, e.rst, e.lost);
      else n_pass++;
    end
  endtask

  task automatic test_loss_in_run();
    exp_t e, obs;
    push_exp(2, 2'd3, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      e = q_exp.pop_front();
      obs = {bus.seq_state, bus.rst_out, bus.lock_lost};
      n_total++;
      if (obs !== e)
        $display("FAIL loss_pre k=%0d got st=%0d rst=%b lost=%b exp st=%0d rst=%b lost=%b",
                 k, obs.st, obs.rst, obs.lost, e.st, e.rst, e.lost);
      else n_pass++;
    end
    bus.pll_lock = 1'b0;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    q_cnt.push_back(2'd1);
`endif
    push_exp(2, 2'd3, 1'b0, 1'b0);
    push_exp(1, 2'd0, 1'b1, 1'b1);
    push_exp(3, 2'd0, 1'b1, 1'b0);
    push_exp(4, 2'd1, 1'b1, 1'b0);
    push_exp(3, 2'd2, 1'b1, 1'b0);
    push_exp(2, 2'd3, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      if (k == 4) bus.pll_lock = 1'b1;
      tick();
      e = q_exp.pop_front();
      obs = {bus.seq_state, bus.rst_out, bus.lock_lost};
      n_total++;
      if (obs !== e)
        $display("FAIL loss_in_run edge=%0d got st=%0d rst=%b lost=%b exp st=%0d rst=%b lost=%b",
                 k, obs.st, obs.rst, obs.lost, e.st, e.rst, e.lost);
      else n_pass++;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
      if (k == 2) begin
        logic [1:0] c;
        c = q_cnt.pop_front();
        n_total++;
        if (bus.loss_count !== c)
          $display("FAIL loss_in_run_count got %0d exp %0d", bus.loss_count, c);
        else n_pass++;
      end
`endif
    end
  endtask

  task automatic test_saturation_clear();
    int got;
    int run_edges;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [1:0] model_cnt = 2'd1;
    logic [1:0] c;
`endif
    // Three more losses on top of the one already counted.
    for (int ev = 0; ev < 3; ev++) begin
      bus.pll_lock = 1'b0;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
      if (model_cnt != 2'd3) model_cnt = model_cnt + 2'd1;
      q_cnt.push_back(model_cnt);
`endif
      got = -1;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (bus.lock_lost === 1'b1) begin
          got = k;
          break;
        end
      end
      n_total++;
      if (got != 2) $display("FAIL sat_pulse_edge ev=%0d got %0d exp 2", ev, got);
      else n_pass++;
      n_total++;
      if (bus.rst_out !== 1'b1) $display("FAIL sat_rst_out ev=%0d got %b exp 1", ev, bus.rst_out);
      else n_pass++;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
      c = q_cnt.pop_front();
      n_total++;
      if (bus.loss_count !== c)
        $display("FAIL sat_count ev=%0d got %0d exp %0d", ev, bus.loss_count, c);
      else n_pass++;
`endif
      tick();
      n_total++;
      if (bus.lock_lost !== 1'b0) $display("FAIL sat_pulse_width ev=%0d got %b exp 0", ev, bus.lock_lost);
      else n_pass++;
      bus.pll_lock = 1'b1;
      run_edges = -1;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (bus.rst_out === 1'b0) begin
          run_edges = k + 1;
          break;
        end
      end
      n_total++;
      if (run_edges != 10 || bus.seq_state !== 2'd3)
        $display("FAIL sat_relock ev=%0d got edges=%0d st=%0d exp edges=10 st=3",
                 ev, run_edges, bus.seq_state);
      else n_pass++;
    end
    // Fifth loss coincides with clear_count.
    bus.pll_lock = 1'b0;
    tick();
    tick();
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    bus.clear_count = 1'b1;
    q_cnt.push_back(2'd1);
`endif
    tick();
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    bus.clear_count = 1'b0;
    c = q_cnt.pop_front();
    n_total++;
    if (bus.loss_count !== c)
      $display("FAIL clear_with_loss got %0d exp %0d", bus.loss_count, c);
    else n_pass++;
`endif
    n_total++;
    if (bus.lock_lost !== 1'b1 || bus.seq_state !== 2'd0)
      $display("FAIL fifth_loss got lost=%b st=%0d exp lost=1 st=0", bus.lock_lost, bus.seq_state);
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    exp_t e, obs;
    bus.pll_lock = 1'b1;
    push_exp(2, 2'd0, 1'b1, 1'b0);
    push_exp(4, 2'd1, 1'b1, 1'b0);
    push_exp(1, 2'd2, 1'b1, 1'b0);
    push_exp(3, 2'd0, 1'b1, 1'b0);
    push_exp(4, 2'd1, 1'b1, 1'b0);
    push_exp(3, 2'd2, 1'b1, 1'b0);
    push_exp(2, 2'd3, 1'b0, 1'b0);
    for (int k = 0; k < 19; k++) begin
      if (k == 7) begin
        reset = 1'b1;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
        q_cnt.push_back(2'd0);
`endif
      end
      if (k == 8) reset = 1'b0;
      tick();
      e = q_exp.pop_front();
      obs = {bus.seq_state, bus.rst_out, bus.lock_lost};
      n_total++;
      if (obs !== e)
        $display("FAIL reset_mid_hold edge=%0d got st=%0d rst=%b lost=%b exp st=%0d rst=%b lost=%b",
                 k, obs.st, obs.rst, obs.lost, e.st, e.rst, e.lost);
      else n_pass++;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
      if (k == 7) begin
        logic [1:0] c;
        c = q_cnt.pop_front();
        n_total++;
        if (bus.loss_count !== c)
          $display("FAIL reset_mid_hold_count got %0d exp %0d", bus.loss_count, c);
        else n_pass++;
      end
`endif
    end
  endtask

  initial begin
    bus.pll_lock = 1'b0;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    bus.clear_count = 1'b0;
`endif
    test_reset();
    test_clean_lock();
    test_glitch_stable();
    test_loss_in_run();
    test_saturation_clear();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
